// File: rtl/pc_seq_pkg.sv
// Purpose : shared types and constants for the LEGv8 fetch/PC sequencer.
// Latency : n/a (declarations only).
// Backpress: n/a.
// Contents: FSM state encoding, PC width, instruction size, branch offset shift.
package pc_seq_pkg;

   localparam int PC_W         = 64;
   localparam int INSTR_BYTES  = 4;
   localparam int BRANCH_SHIFT = 2;

   typedef logic [PC_W-1:0] pc_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_EXEC   = 3'd2,
      ST_HALTED = 3'd3,
      ST_FAULT  = 3'd4
   } seq_state_t;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Purpose : instruction-memory fetch handshake bundle.
// Latency : n/a (wires only).
// Backpress: memory holds off the sequencer by withholding imem_ack.
// Ports   : imem_req (fetch request), imem_addr (fetch address), imem_ack (word fetched).
interface pc_fetch_sequencer_if;
   import pc_seq_pkg::*;

   logic imem_req;
   pc_t  imem_addr;
   logic imem_ack;

   modport master (output imem_req, output imem_addr, input imem_ack);
   modport slave  (input imem_req, input imem_addr, output imem_ack);

endinterface

// File: rtl/pc_target_calc.sv
// Purpose : next-PC resolution from the datapath branch controls.
// Latency : combinational, zero cycles.
// Backpress: none.
// Ports   : cur_pc, imm (sign-extended word offset), branch/alu_zero/uncond in;
//           next_pc (PC+4 or PC+imm*4, modulo 2^64) and taken out.
module pc_target_calc
   import pc_seq_pkg::*;
(
   input  pc_t  cur_pc,
   input  pc_t  imm,
   input  logic branch,
   input  logic alu_zero,
   input  logic uncond,
   output pc_t  next_pc,
   output logic taken
);

   pc_t offset;

   always_comb begin
      taken   = uncond | (branch & alu_zero);
      // Word offset becomes a byte offset; the top two imm bits fall off, which
      // is exactly the modulo-2^64 behaviour wanted.
      offset  = taken ? (imm << BRANCH_SHIFT) : pc_t'(INSTR_BYTES);
      next_pc = cur_pc + offset;
   end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Purpose : LEGv8 multi-cycle fetch sequencer: owns the PC, fetches over imem, strobes execute.
// Latency : IDLE 1 cycle after reset; then >= 2 cycles per instruction (REQ + EXEC).
// Backpress: stays in REQ until imem_ack; IMEM_TIMEOUT REQ cycles without ack -> FAULT.
// Ports   : CLK, Reset (sync, active-high); imem (fetch handshake, master side);
//           Branch/ALUZero/Uncondbranch/SignExtImm64/Halt sampled in EXEC only;
//           instr_valid, CurrentPC, halted, fault, retired_count are Moore outputs.
module pc_fetch_sequencer
   import pc_seq_pkg::*;
#(
   parameter pc_t RESET_PC     = '0,
   parameter int  IMEM_TIMEOUT = 15
)
(
   input  logic                        CLK,
   input  logic                        Reset,
   pc_fetch_sequencer_if.master        imem,
   output logic                        instr_valid,
   input  logic                        Branch,
   input  logic                        ALUZero,
   input  logic                        Uncondbranch,
   input  pc_t                         SignExtImm64,
   input  logic                        Halt,
   output pc_t                         CurrentPC,
   output logic                        halted,
   output logic                        fault,
   output logic [31:0]                 retired_count
);

   localparam logic [7:0] TMO_TERM = 8'(IMEM_TIMEOUT);

   seq_state_t  state, state_nxt;
   pc_t         pc, pc_nxt;
   logic [7:0]  tcnt, tcnt_nxt;
   logic [31:0] retired, retired_nxt;
   pc_t         target_pc;
   logic        taken_unused;   // already folded into target_pc; kept for probing

   pc_target_calc u_target (
      .cur_pc   (pc),
      .imm      (SignExtImm64),
      .branch   (Branch),
      .alu_zero (ALUZero),
      .uncond   (Uncondbranch),
      .next_pc  (target_pc),
      .taken    (taken_unused)
   );

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state   <= ST_IDLE;
         pc      <= RESET_PC;
         tcnt    <= '0;
         retired <= '0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         tcnt    <= tcnt_nxt;
         retired <= retired_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      tcnt_nxt    = tcnt;
      retired_nxt = retired;
      case (state)
         ST_IDLE: begin
            state_nxt = ST_REQ;
            tcnt_nxt  = '0;
         end
         ST_REQ: begin
            // Ack is checked first so an ack on the terminal cycle still fetches.
            if (imem.imem_ack) begin
               state_nxt = ST_EXEC;
            end else begin
               tcnt_nxt = tcnt + 8'd1;
               if (tcnt + 8'd1 == TMO_TERM) begin
                  state_nxt = ST_FAULT;
               end
            end
         end
         ST_EXEC: begin
            retired_nxt = retired + 32'd1;
            if (Halt) begin
               state_nxt = ST_HALTED;
            end else begin
               pc_nxt    = target_pc;
               tcnt_nxt  = '0;
               state_nxt = ST_REQ;
            end
         end
         ST_HALTED: state_nxt = ST_HALTED;
         ST_FAULT:  state_nxt = ST_FAULT;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   assign imem.imem_req  = (state == ST_REQ);
   assign imem.imem_addr = pc;
   assign instr_valid    = (state == ST_EXEC);
   assign halted         = (state == ST_HALTED);
   assign fault          = (state == ST_FAULT);
   assign CurrentPC      = pc;
   assign retired_count  = retired;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Purpose : self-checking bench for pc_fetch_sequencer (branch table, timeout, halt, reset).
// Latency : n/a.
// Backpress: bench plays the memory and varies ack delay.
module tb_pc_fetch_sequencer;
   import pc_seq_pkg::*;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic        instr_valid;
   logic        Branch = 1'b0;
   logic        ALUZero = 1'b0;
   logic        Uncondbranch = 1'b0;
   logic [63:0] SignExtImm64 = '0;
   logic        Halt = 1'b0;
   logic [63:0] CurrentPC;
   logic        halted;
   logic        fault;
   logic [31:0] retired_count;

   always #5 CLK = ~CLK;

   pc_fetch_sequencer_if imem_bus();

   pc_fetch_sequencer #(.RESET_PC(64'h0), .IMEM_TIMEOUT(15)) dut (
      .CLK           (CLK),
      .Reset         (Reset),
      .imem          (imem_bus),
      .instr_valid   (instr_valid),
      .Branch        (Branch),
      .ALUZero       (ALUZero),
      .Uncondbranch  (Uncondbranch),
      .SignExtImm64  (SignExtImm64),
      .Halt          (Halt),
      .CurrentPC     (CurrentPC),
      .halted        (halted),
      .fault         (fault),
      .retired_count (retired_count)
   );

   typedef struct {
      logic        br;
      logic        az;
      logic        ub;
      logic [63:0] imm;
      int          dly;
      logic [63:0] exp_addr;
   } vec_t;

   vec_t        vt [12];
   logic [63:0] sb_q [$];
   logic [63:0] m_pc;
   logic [31:0] m_ret;
   int          tests = 0;
   int          fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Junk on the datapath controls outside EXEC must have no effect.
   task automatic junk_ctl();
      Branch       = 1'($urandom);
      ALUZero      = 1'($urandom);
      Uncondbranch = 1'($urandom);
      SignExtImm64 = {$urandom, $urandom};
      Halt         = 1'b0;
   endtask

   // Ends on a negedge with Reset just released: DUT is in its IDLE cycle.
   task automatic apply_reset();
      @(negedge CLK);
      Reset = 1'b1;
      imem_bus.imem_ack = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      Reset = 1'b0;
      m_pc  = 64'h0;
      m_ret = 32'h0;
      sb_q.delete();
   endtask

   // Entered at a negedge on the first REQ cycle; leaves at a negedge on the next REQ cycle.
   task automatic exec_one(input vec_t v, input string nm);
      logic [63:0] exp;
      for (int i = 0; i < v.dly; i++) begin
         imem_bus.imem_ack = 1'b0;
         @(negedge CLK);
         chk({nm, " req_held"}, {63'h0, imem_bus.imem_req}, 64'h1);
         chk({nm, " addr_stable"}, imem_bus.imem_addr, m_pc);
      end
      imem_bus.imem_ack = 1'b1;
      @(negedge CLK);
      chk({nm, " instr_valid"}, {63'h0, instr_valid}, 64'h1);
      imem_bus.imem_ack = 1'b0;
      Branch       = v.br;
      ALUZero      = v.az;
      Uncondbranch = v.ub;
      SignExtImm64 = v.imm;
      Halt         = 1'b0;
      sb_q.push_back(v.exp_addr);
      m_ret++;
      @(negedge CLK);
      junk_ctl();
      chk({nm, " req"}, {63'h0, imem_bus.imem_req}, 64'h1);
      if (sb_q.size() == 0) begin
         exp = 64'hDEAD_DEAD_DEAD_DEAD;
      end else begin
         exp = sb_q.pop_front();
      end
      chk({nm, " next_addr"}, imem_bus.imem_addr, exp);
      chk({nm, " retired"}, {32'h0, retired_count}, {32'h0, m_ret});
      chk({nm, " fault"}, {63'h0, fault}, 64'h0);
      m_pc = exp;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int nreq;
      int seen;
      imem_bus.imem_ack = 1'b0;

      //           br    az    ub    imm                     dly exp_addr
      vt[0]  = '{1'b0, 1'b0, 1'b0, 64'h0,                   0, 64'h4};
      vt[1]  = '{1'b0, 1'b0, 1'b1, 64'h3F,                  1, 64'h100};
      vt[2]  = '{1'b1, 1'b1, 1'b0, 64'h10,                  0, 64'h140};
      vt[3]  = '{1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 2, 64'h100};
      vt[4]  = '{1'b1, 1'b0, 1'b0, 64'h10,                  0, 64'h104};
      vt[5]  = '{1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3, 64'h100};
      vt[6]  = '{1'b0, 1'b1, 1'b0, 64'h10,                  0, 64'h104};
      vt[7]  = '{1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h100};
      vt[8]  = '{1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 64'hF8};
      vt[9]  = '{1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFC1, 0, 64'hFFFF_FFFF_FFFF_FFFC};
      vt[10] = '{1'b0, 1'b0, 1'b0, 64'h1234,                2, 64'h0};
      vt[11] = '{1'b1, 1'b1, 1'b0, 64'h80,                  0, 64'h200};

      // Reset state and the single IDLE cycle.
      apply_reset();
      chk("rst imem_req", {63'h0, imem_bus.imem_req}, 64'h0);
      chk("rst instr_valid", {63'h0, instr_valid}, 64'h0);
      chk("rst halted", {63'h0, halted}, 64'h0);
      chk("rst fault", {63'h0, fault}, 64'h0);
      chk("rst pc", CurrentPC, 64'h0);
      chk("rst retired", {32'h0, retired_count}, 64'h0);
      @(negedge CLK);
      chk("first req", {63'h0, imem_bus.imem_req}, 64'h1);
      chk("first addr", imem_bus.imem_addr, 64'h0);

      for (int i = 0; i < 12; i++) begin
         exec_one(vt[i], $sformatf("vec%0d", i));
      end

      // Halt with a concurrent unconditional branch at 0x200.
      imem_bus.imem_ack = 1'b1;
      @(negedge CLK);
      chk("halt instr_valid", {63'h0, instr_valid}, 64'h1);
      imem_bus.imem_ack = 1'b0;
      Halt = 1'b1; Uncondbranch = 1'b1; Branch = 1'b1; ALUZero = 1'b1; SignExtImm64 = 64'h5;
      m_ret++;
      @(negedge CLK);
      junk_ctl();
      chk("halt halted", {63'h0, halted}, 64'h1);
      chk("halt pc", CurrentPC, 64'h200);
      chk("halt retired", {32'h0, retired_count}, {32'h0, m_ret});
      imem_bus.imem_ack = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (imem_bus.imem_req || instr_valid || !halted) seen++;
      end
      chk("halt absorbing", 64'(seen), 64'h0);
      apply_reset();
      chk("halt->rst pc", CurrentPC, 64'h0);
      chk("halt->rst halted", {63'h0, halted}, 64'h0);

      // Fetch timeout: no ack for 15 REQ cycles.
      @(negedge CLK);
      nreq = 0;
      for (int i = 0; i < 15; i++) begin
         if (imem_bus.imem_req) nreq++;
         @(negedge CLK);
      end
      chk("tmo req cycles", 64'(nreq), 64'd15);
      chk("tmo fault", {63'h0, fault}, 64'h1);
      chk("tmo req off", {63'h0, imem_bus.imem_req}, 64'h0);
      imem_bus.imem_ack = 1'b1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         if (!fault || imem_bus.imem_req || instr_valid) seen++;
      end
      chk("tmo fault held", 64'(seen), 64'h0);
      apply_reset();
      chk("tmo->rst fault", {63'h0, fault}, 64'h0);

      // Ack arriving exactly on the 15th REQ cycle wins over the timeout.
      @(negedge CLK);
      exec_one('{1'b0, 1'b0, 1'b0, 64'h0, 14, 64'h4}, "tmo_edge");

      // Reset concurrent with ack during REQ discards the fetch.
      imem_bus.imem_ack = 1'b1;
      Reset = 1'b1;
      @(negedge CLK);
      chk("rstack instr_valid", {63'h0, instr_valid}, 64'h0);
      chk("rstack req", {63'h0, imem_bus.imem_req}, 64'h0);
      chk("rstack pc", CurrentPC, 64'h0);
      chk("rstack retired", {32'h0, retired_count}, 64'h0);
      Reset = 1'b0;
      imem_bus.imem_ack = 1'b0;
      @(negedge CLK);
      chk("rstack then req", {63'h0, imem_bus.imem_req}, 64'h1);
      chk("rstack then addr", imem_bus.imem_addr, 64'h0);
      chk("rstack no exec", {63'h0, instr_valid}, 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
